// File: rtl/mac_pipe_sat_if.sv
// Operand/result bundle for mac_pipe_sat: valid-qualified operand stream in,
// accumulator value with per-sample valid and overflow flags out.
interface mac_pipe_sat_if #(
    parameter int IN_W  = 14,
    parameter int ACC_W = 28
);
    logic signed [IN_W-1:0]  a;
    logic signed [IN_W-1:0]  b;
    logic                    valid_in;
    logic                    clear_in;
    logic signed [ACC_W-1:0] f;
    logic                    valid_out;
    logic                    ovf_out;

    modport master (
        output a, b, valid_in, clear_in,
        input  f, valid_out, ovf_out
    );

    modport slave (
        input  a, b, valid_in, clear_in,
        output f, valid_out, ovf_out
    );
endinterface

// File: rtl/mac_pipe_sat.sv
// Pipelined signed multiply-accumulate with per-result overflow flag and clear.
// Build option MAC_SAT_EN: saturate on overflow; undefined wraps (two's complement).
module mac_pipe_sat #(
    parameter int IN_W        = 14,
    parameter int ACC_W       = 28,
    parameter int PIPE_STAGES = 3
) (
    input  logic          clk,
    input  logic          reset,
    mac_pipe_sat_if.slave bus
);
    localparam int PROD_W = 2 * IN_W;
    localparam int LAST   = PIPE_STAGES - 1;

    if (ACC_W < 2 * IN_W) begin : g_bad_acc_w
        $error("mac_pipe_sat: ACC_W must be >= 2*IN_W");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_pipe
        $error("mac_pipe_sat: PIPE_STAGES must be in 1..8");
    end

    logic signed [IN_W-1:0]   a_r, b_r;
    logic                     vld_r, clr_r;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]   vld_q, clr_q;

    logic signed [ACC_W-1:0]  f_q, f_d;
    logic                     vout_q, vout_d;
    logic                     ovf_q, ovf_d;
    logic signed [ACC_W:0]    f_ext, p_ext, s;
    logic                     s_ovf;
    logic signed [ACC_W-1:0]  s_fit;

    // Operands are zeroed on bubbles so undefined a/b never enter the product path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r   <= '0;
            b_r   <= '0;
            vld_r <= 1'b0;
            clr_r <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
            a_r   <= bus.valid_in ? bus.a : '0;
            b_r   <= bus.valid_in ? bus.b : '0;
            vld_r <= bus.valid_in;
            clr_r <= bus.clear_in;
        end
    end

    assign prod_d = PROD_W'(a_r) * PROD_W'(b_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the product array is reset too, so a reset mid-stream flushes every in-flight sample.
            for (int i = 0; i < PIPE_STAGES; i++) begin
                prod_q[i] <= '0;
            end
            vld_q <= '0;
            clr_q <= '0;
        end else begin
            prod_q[0] <= prod_d;
            vld_q[0]  <= vld_r;
            clr_q[0]  <= clr_r;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
                vld_q[i]  <= vld_q[i-1];
                clr_q[i]  <= clr_q[i-1];
            end
        end
    end

    // One guard bit above the accumulator exposes overflow as a sign disagreement.
    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        f_d    = f_q;
        vout_d = 1'b0;
        ovf_d  = 1'b0;
        f_ext  = (ACC_W+1)'(f_q);
        p_ext  = (ACC_W+1)'(prod_q[LAST]);
        s      = f_ext + p_ext;
        s_ovf  = s[ACC_W] ^ s[ACC_W-1];
`ifdef MAC_SAT_EN
        if (s_ovf) begin
            s_fit = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            s_fit = s[ACC_W-1:0];
        end
`else
        s_fit = s[ACC_W-1:0];
`endif
        if (vld_q[LAST]) begin
            vout_d = 1'b1;
            if (clr_q[LAST]) begin
                f_d = p_ext[ACC_W-1:0];
            end else begin
                f_d   = s_fit;
                ovf_d = s_ovf;
            end
        end else if (clr_q[LAST]) begin
            f_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_q    <= '0;
            vout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            f_q    <= f_d;
            vout_q <= vout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.f         = f_q;
    assign bus.valid_out = vout_q;
    assign bus.ovf_out   = ovf_q;
endmodule
